// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate extender with a two-entry skid buffer
// The main register drives the outputs; the skid register absorbs one entry while the consumer stalls.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INS,
    input  logic [2:0]       TYPE,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  IMM_EXT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ERR
);

    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [2:0] FMT_Z = 3'd6;
    localparam logic [2:0] FMT_X = 3'd7;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_in_xfer;
    logic             w_main_free;
    logic             w_unused;

    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_err;
    logic             r_main_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_err;
    logic             r_skid_valid;

    // The opcode field never contributes to the immediate.
    assign w_unused = &{1'b0, INS[6:0]};

    // Signed casts to XLEN perform the sign extension from each format's top bit.
    always_comb begin
        w_imm = '0;
        case (TYPE)
            FMT_I:   w_imm = XLEN'($signed(INS[31:20]));
            FMT_S:   w_imm = XLEN'($signed({INS[31:25], INS[11:7]}));
            FMT_B:   w_imm = XLEN'($signed({INS[31], INS[7], INS[30:25], INS[11:8], 1'b0}));
            FMT_U:   w_imm = XLEN'($signed({INS[31:12], 12'b0}));
            FMT_J:   w_imm = XLEN'($signed({INS[31], INS[19:12], INS[20], INS[30:21], 1'b0}));
            FMT_Z:   w_imm = XLEN'(INS[19:15]);
            default: w_imm = '0;
        endcase
    end

    assign w_err       = (TYPE == FMT_X);
    assign w_in_xfer   = IN_VALID & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | OUT_READY;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_main_imm   <= '0;
            r_main_tag   <= '0;
            r_main_err   <= 1'b0;
            r_main_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (FLUSH) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_imm   <= r_skid_imm;
                r_main_tag   <= r_skid_tag;
                r_main_err   <= r_skid_err;
                r_main_valid <= 1'b1;
                r_skid_valid <= w_in_xfer;
                if (w_in_xfer) begin
                    r_skid_imm <= w_imm;
                    r_skid_tag <= IN_TAG;
                    r_skid_err <= w_err;
                end
            end else if (w_in_xfer) begin
                r_main_imm   <= w_imm;
                r_main_tag   <= IN_TAG;
                r_main_err   <= w_err;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            // Main is full and stalled: park the new entry.
            r_skid_imm   <= w_imm;
            r_skid_tag   <= IN_TAG;
            r_skid_err   <= w_err;
            r_skid_valid <= 1'b1;
        end
    end

    assign IN_READY  = ~r_skid_valid;
    assign OUT_VALID = r_main_valid;
    assign IMM_EXT   = r_main_imm;
    assign OUT_TAG   = r_main_tag;
    assign OUT_ERR   = r_main_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed and randomised checks of imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] ins = '0;
    logic [2:0]  typ = '0;
    logic [7:0]  in_tag = '0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] imm32;
    logic [7:0]  out_tag;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] imm64;
    logic [7:0]  out_tag64;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } entry_t;

    entry_t q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready),
        .INS(ins), .TYPE(typ), .IN_TAG(in_tag),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .IMM_EXT(imm32), .OUT_TAG(out_tag), .OUT_ERR(out_err)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .CLK(clk), .RST(rst), .FLUSH(flush),
        .IN_VALID(in_valid), .IN_READY(in_ready64),
        .INS(ins), .TYPE(typ), .IN_TAG(in_tag),
        .OUT_VALID(out_valid64), .OUT_READY(out_ready),
        .IMM_EXT(imm64), .OUT_TAG(out_tag64), .OUT_ERR(out_err64)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
        case (t)
            3'd1:    ref_imm = {{52{i[31]}}, i[31:20]};
            3'd2:    ref_imm = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3:    ref_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4:    ref_imm = {{32{i[31]}}, i[31:12], 12'h000};
            3'd5:    ref_imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6:    ref_imm = {59'd0, i[19:15]};
            default: ref_imm = 64'd0;
        endcase
    endfunction

    task automatic test_reset;
        tick();
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imm32 !== 32'd0 || in_ready !== 1'b1 || out_tag !== 8'd0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: valid=%b imm=%h rdy=%b tag=%h err=%b, need 0 0 1 0 0", out_valid, imm32, in_ready, out_tag, out_err);
        end
        tick();
        #3 rst = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || imm32 !== 32'd0 || in_ready !== 1'b1 || imm64 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b imm=%h rdy=%b imm64=%h, need 0 0 1 0", out_valid, imm32, in_ready, imm64);
        end
    endtask

    task automatic test_formats;
        logic [31:0] v_ins [10];
        logic [2:0]  v_typ [10];
        logic [63:0] v_e64 [10];
        logic [31:0] v_e32 [10];
        v_ins[0] = 32'hFFF00093; v_typ[0] = 3'd1; v_e64[0] = 64'hFFFFFFFF_FFFFFFFF; v_e32[0] = 32'hFFFFFFFF;
        v_ins[1] = 32'hFE112E23; v_typ[1] = 3'd2; v_e64[1] = 64'hFFFFFFFF_FFFFFFFC; v_e32[1] = 32'hFFFFFFFC;
        v_ins[2] = 32'hFFFFFFFF; v_typ[2] = 3'd3; v_e64[2] = 64'hFFFFFFFF_FFFFFFFE; v_e32[2] = 32'hFFFFFFFE;
        v_ins[3] = 32'hFFFFFFFF; v_typ[3] = 3'd5; v_e64[3] = 64'hFFFFFFFF_FFFFFFFE; v_e32[3] = 32'hFFFFFFFE;
        v_ins[4] = 32'h12345037; v_typ[4] = 3'd4; v_e64[4] = 64'h00000000_12345000; v_e32[4] = 32'h12345000;
        v_ins[5] = 32'h000F8000; v_typ[5] = 3'd6; v_e64[5] = 64'h00000000_0000001F; v_e32[5] = 32'h0000001F;
        v_ins[6] = 32'hFFFFFFFF; v_typ[6] = 3'd0; v_e64[6] = 64'h0;                 v_e32[6] = 32'h0;
        v_ins[7] = 32'hFFFFFFFF; v_typ[7] = 3'd7; v_e64[7] = 64'h0;                 v_e32[7] = 32'h0;
        v_ins[8] = 32'h80000037; v_typ[8] = 3'd4; v_e64[8] = 64'hFFFFFFFF_80000000; v_e32[8] = 32'h80000000;
        v_ins[9] = 32'h7FF00013; v_typ[9] = 3'd1; v_e64[9] = 64'h00000000_000007FF; v_e32[9] = 32'h000007FF;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            ins      = v_ins[i];
            typ      = v_typ[i];
            in_tag   = 8'(8'h20 + i);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fmt_in_ready[%0d]: got %b need 1", i, in_ready);
            end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || imm32 !== v_e32[i] || out_tag !== 8'(8'h20 + i) || out_err !== (v_typ[i] == 3'd7)) begin
                n_fail++;
                $display("FAIL fmt32[%0d]: valid=%b imm=%h tag=%h err=%b, need 1 %h %h %b",
                         i, out_valid, imm32, out_tag, out_err, v_e32[i], 8'(8'h20 + i), v_typ[i] == 3'd7);
            end
            n_tests++;
            if (out_valid64 !== 1'b1 || imm64 !== v_e64[i] || out_err64 !== (v_typ[i] == 3'd7)) begin
                n_fail++;
                $display("FAIL fmt64[%0d]: valid=%b imm=%h err=%b, need 1 %h %b",
                         i, out_valid64, imm64, out_err64, v_e64[i], v_typ[i] == 3'd7);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fmt_drain: valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_back_pressure;
        int          sent;
        int          exp_tag;
        logic [31:0] held;
        bit          acc_in;
        out_ready = 1'b0;
        typ       = 3'd1;
        in_valid  = 1'b1;
        in_tag    = 8'd1;
        ins       = {12'h011, 20'h00013};
        tick();
        held = imm32;
        n_tests++;
        if (out_valid !== 1'b1 || out_tag !== 8'd1 || imm32 !== 32'h11) begin
            n_fail++;
            $display("FAIL bp_first: valid=%b tag=%h imm=%h, need 1 01 00000011", out_valid, out_tag, imm32);
        end
        in_tag = 8'd2;
        ins    = {12'h022, 20'h00013};
        tick();
        in_tag = 8'd3;
        ins    = {12'h033, 20'h00013};
        n_tests++;
        if (in_ready !== 1'b0 || out_tag !== 8'd1 || imm32 !== held) begin
            n_fail++;
            $display("FAIL bp_full: rdy=%b tag=%h imm=%h, need 0 01 %h", in_ready, out_tag, imm32, held);
        end
        tick();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'd1 || imm32 !== held) begin
            n_fail++;
            $display("FAIL bp_stall: rdy=%b valid=%b tag=%h imm=%h, need 0 1 01 %h", in_ready, out_valid, out_tag, imm32, held);
        end
        out_ready = 1'b1;
        sent      = 3;
        exp_tag   = 1;
        for (int c = 0; c < 20 && exp_tag <= 4; c++) begin
            acc_in = in_valid & in_ready;
            if (out_valid) begin
                n_tests++;
                if (out_tag !== 8'(exp_tag) || imm32 !== 32'(exp_tag * 32'h11)) begin
                    n_fail++;
                    $display("FAIL bp_order: tag=%h imm=%h, need %h %h", out_tag, imm32, 8'(exp_tag), 32'(exp_tag * 32'h11));
                end
                exp_tag++;
            end
            tick();
            if (acc_in) sent++;
            in_valid = (sent <= 4);
            in_tag   = 8'(sent);
            ins      = {12'(sent * 12'h011), 20'h00013};
        end
        n_tests++;
        if (exp_tag != 5) begin
            n_fail++;
            $display("FAIL bp_count: delivered %0d entries, need 4", exp_tag - 1);
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: valid=%b tag=%h, need valid 0", out_valid, out_tag);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        typ       = 3'd1;
        ins       = 32'h12300013;
        in_valid  = 1'b1;
        in_tag    = 8'd5;
        tick();
        in_tag = 8'd6;
        tick();
        flush  = 1'b1;
        in_tag = 8'd9;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full: valid=%b rdy=%b, need 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1;
        in_tag   = 8'd7;
        tick();
        flush    = 1'b1;
        in_tag   = 8'd9;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_drop[%0d]: valid=%b tag=%h rdy=%b, need 0 - 1", c, out_valid, out_tag, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        typ       = 3'd7;
        in_tag    = 8'hA5;
        tick();
        tick();
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || imm32 !== 32'd0 || out_tag !== 8'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: valid=%b imm=%h tag=%h err=%b rdy=%b, need 0 0 0 0 1", out_valid, imm32, out_tag, out_err, in_ready);
        end
        in_valid = 1'b0;
        tick();
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_random;
        bit     acc_in, acc_out;
        entry_t e;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 199) == 0);
            ins       = $urandom;
            typ       = 3'($urandom_range(0, 7));
            in_tag    = 8'($urandom);
            n_tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)
                || out_valid64 !== out_valid || in_ready64 !== in_ready) begin
                n_fail++;
                $display("FAIL rnd_state[%0d]: valid=%b rdy=%b v64=%b r64=%b, model occupancy %0d", c, out_valid, in_ready, out_valid64, in_ready64, q.size());
            end
            if (out_valid === 1'b1 && q.size() > 0) begin
                n_tests++;
                if (imm32 !== q[0].imm[31:0] || imm64 !== q[0].imm || out_tag !== q[0].tag
                    || out_err !== q[0].err || out_tag64 !== q[0].tag || out_err64 !== q[0].err) begin
                    n_fail++;
                    $display("FAIL rnd_data[%0d]: imm=%h imm64=%h tag=%h err=%b, need %h %h %h %b",
                             c, imm32, imm64, out_tag, out_err, q[0].imm[31:0], q[0].imm, q[0].tag, q[0].err);
                end
            end
            acc_in  = in_valid & in_ready;
            acc_out = out_valid & out_ready;
            e.imm   = ref_imm(ins, typ);
            e.tag   = in_tag;
            e.err   = (typ == 3'd7);
            tick();
            if (flush) begin
                q.delete();
            end else begin
                if (acc_out) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rnd_phantom[%0d]: output transfer with no accepted input", c);
                    end else begin
                        void'(q.pop_front());
                    end
                end
                if (acc_in) q.push_back(e);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_pressure();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender in the decode stage.
- Accepts an instruction word, a 3-bit format code and a sideband tag over a valid/ready handshake.
- Returns the XLEN-wide extended immediate one cycle later through a two-entry skid buffer, so decode back-pressure never creates a combinational ready path.
- Adds RV64 support (XLEN), a CSR zero-extended immediate format, a reserved-format error flag and a synchronous flush.

Parameters:
- XLEN, 32, output immediate width. Legal values: 32 or 64; any other value is a fatal elaboration error.
- TAG_W, 8, width of the opaque sideband tag (e.g. ROB index or PC slice), carried alongside each entry.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- FLUSH  input  1  synchronous flush; drops all buffered entries
- IN_VALID  input  1  input entry valid
- IN_READY  output  1  block can accept an entry this cycle
- INS  input  32  instruction word
- TYPE  input  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR uimm), 7=reserved
- IN_TAG  input  TAG_W  sideband tag
- OUT_VALID  output  1  output entry valid
- OUT_READY  input  1  consumer accepts the output entry
- IMM_EXT  output  XLEN  extended immediate
- OUT_TAG  output  TAG_W  tag of the output entry
- OUT_ERR  output  1  the output entry had TYPE=7

Behaviour:
- Extension is combinational on INS/TYPE. The result is captured into registers; there is no combinational path from inputs to outputs.
- Let s = INS[31]. Each result is sign-extended from the stated bit to XLEN unless noted:
  - I: INS[31:20], extended from bit 11.
  - S: {INS[31:25], INS[11:7]}, extended from bit 11.
  - B: {INS[31], INS[7], INS[30:25], INS[11:8], 0}, extended from bit 12.
  - U: {INS[31:12], 12'b0}. When XLEN=64, bits 63:32 = s.
  - J: {INS[31], INS[19:12], INS[20], INS[30:21], 0}, extended from bit 20.
  - Z: zero-extended INS[19:15].
  - R: all zeros.
  - Reserved (7): all zeros, with OUT_ERR=1 for that entry.
- Storage is a main register (drives the outputs) plus a skid register. Each holds {imm, tag, err, valid}.
- IN_READY = ~skid_valid. It is registered and depends only on state.
- An input transfer occurs when IN_VALID & IN_READY. An output transfer occurs when OUT_VALID & OUT_READY.
- Per cycle, no flush:
  - If main is empty, or main transfers out this cycle: main loads the skid entry if skid is valid, otherwise main loads the input entry if one is transferring in. The skid register is cleared when its entry moves to main.
  - Else (main full and stalled) with an input transfer: the input entry goes into skid.
  - If skid moves to main and an input also transfers in during the same cycle, the input entry goes into skid.
- Latency: 1 cycle from input transfer to OUT_VALID when main is empty. Ordering is strictly FIFO.
- Throughput: 1 entry per cycle while OUT_READY=1.
- Full condition: main and skid both valid. Then IN_READY=0, and IN_VALID is ignored with no state change.
- FLUSH=1 (synchronous, wins over all transfers in the same cycle): both valid bits are cleared at the edge, and an input presented that cycle is discarded. Next cycle OUT_VALID=0 and IN_READY=1.
- Reset (asynchronous, may assert mid-transfer): OUT_VALID=0, IMM_EXT=0, OUT_TAG=0, OUT_ERR=0, IN_READY=1, skid cleared. Outputs take these values immediately on assertion, without waiting for a clock edge.
- Output stability: IMM_EXT, OUT_TAG and OUT_ERR hold their values while OUT_VALID=1 and OUT_READY=0.
- Payload of an invalid entry is don't-care, but the main payload register only updates on load.

Test Plan:
- Reset/idle: assert RST between clock edges -> OUT_VALID=0, IMM_EXT=0 and IN_READY=1 immediately. Deassert RST -> same values hold.
- Per-format results, XLEN=32, OUT_READY=1:
  - I, INS=0xFFF00093 -> 0xFFFFFFFF.
  - S, INS=0xFE112E23 -> 0xFFFFFFFC.
  - B, INS=0xFFFFFFFF -> 0xFFFFFFFE.
  - J, INS=0xFFFFFFFF -> 0xFFFFFFFE.
  - U, INS=0x12345037 -> 0x12345000.
  - Z, INS=0x000F8000 -> 0x0000001F.
  - R -> 0.
  - TYPE=7 -> 0 with OUT_ERR=1.
  - Each result appears exactly 1 cycle after its input transfer.
- XLEN=64: U, INS=0x80000037 -> 0xFFFFFFFF80000000. I, INS=0x7FF00013 -> 0x00000000000007FF.
- Back-pressure: stream tags 1,2,3,4 with OUT_READY=0 for 3 cycles:
  - Main holds tag 1, skid holds tag 2, IN_READY=0; tags 3 and 4 wait.
  - After OUT_READY=1, outputs arrive in order 1,2,3,4 with no loss or duplication.
  - IMM_EXT stays stable during the stall.
- Flush: with main and skid both full, assert FLUSH together with IN_VALID (tag 9) -> next cycle OUT_VALID=0 and IN_READY=1, and tag 9 never appears on the output.
- Random stress: random IN_VALID/OUT_READY over 10k cycles against a reference model -> order, values and OUT_ERR all match, and no output transfer ever occurs without a corresponding accepted input.
